// File: rtl/dec_timer_pkg.sv
// Shared state type and state encodings for the dec_timer down-counting timer.
package dec_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } dec_timer_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_EXPIRE = 2'd2;

endpackage

// File: rtl/dec_timer_dec.sv
// Generic combinational decrementer: {borrow_o, y_o} = x_i - 1, the mirror of an incrementer.
module dec_timer_dec #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o,
    output logic         borrow_o
);

    assign {borrow_o, y_o} = {1'b0, x_i} - (W+1)'(1);

endmodule

// File: rtl/dec_timer.sv
// Loadable down-counting timer with valid/ready load and expiry ports.
// Optional periodic auto-reload enabled by defining DEC_TIMER_AUTORELOAD_EN.
module dec_timer
    import dec_timer_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_vld_i,
    input  logic [W-1:0] load_cnt_i,
    output logic         load_rdy_o,
    input  logic         abort_i,
    output logic         expire_vld_o,
    input  logic         expire_rdy_i,
    output logic [W-1:0] cnt_o,
    output logic         busy_o
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] dec_y;
    logic         borrow;
`ifdef DEC_TIMER_AUTORELOAD_EN
    logic [W-1:0] reload_q, reload_d;
`endif

    dec_timer_dec #(.W(W)) u_dec (
        .x_i      (cnt_q),
        .y_o      (dec_y),
        .borrow_o (borrow)
    );

    // Next-state and next-count logic; abort takes priority in RUN and EXPIRE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
`ifdef DEC_TIMER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_vld_i) begin
`ifdef DEC_TIMER_AUTORELOAD_EN
                    reload_d = load_cnt_i;
`endif
                    cnt_d = load_cnt_i;
                    if (load_cnt_i == '0) begin
                        state_d = ST_EXPIRE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef DEC_TIMER_AUTORELOAD_EN
                    reload_d = '0;
`endif
                end else begin
                    cnt_d = dec_y;
                    if (dec_y == '0) begin
                        state_d = ST_EXPIRE;
                    end
                end
            end
            ST_EXPIRE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef DEC_TIMER_AUTORELOAD_EN
                    reload_d = '0;
`endif
                end else if (expire_rdy_i) begin
`ifdef DEC_TIMER_AUTORELOAD_EN
                    if (reload_q != '0) begin
                        state_d = ST_RUN;
                        cnt_d   = reload_q;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
`else
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
`ifdef DEC_TIMER_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`ifdef DEC_TIMER_AUTORELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    // The count is never zero while running, so the decrement cannot borrow there.
    assert property (@(posedge clk) disable iff (!rst_n) (state_q == ST_RUN) |-> !borrow);

    assign load_rdy_o   = (state_q == ST_IDLE);
    assign expire_vld_o = (state_q == ST_EXPIRE);
    assign busy_o       = (state_q != ST_IDLE);
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_dec_timer.sv
// Self-checking bench for dec_timer against a deadline-based reference model.
module tb_dec_timer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_vld_i;
    logic [W-1:0] load_cnt_i;
    logic         load_rdy_o;
    logic         abort_i;
    logic         expire_vld_o;
    logic         expire_rdy_i;
    logic [W-1:0] cnt_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    // Model: a running timer is described by the absolute cycle at which it expires.
    bit           m_active   = 1'b0;
    longint       m_deadline = 0;
    longint       m_cyc      = 0;
    logic [W-1:0] m_reload   = '0;

    always #5 clk = ~clk;

    dec_timer #(.W(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_vld_i   (load_vld_i),
        .load_cnt_i   (load_cnt_i),
        .load_rdy_o   (load_rdy_o),
        .abort_i      (abort_i),
        .expire_vld_o (expire_vld_o),
        .expire_rdy_i (expire_rdy_i),
        .cnt_o        (cnt_o),
        .busy_o       (busy_o)
    );

    wire [W+2:0] dut_out = {load_rdy_o, expire_vld_o, busy_o, cnt_o};

    localparam logic [W+2:0] IDLE_OUT = {1'b1, 1'b0, 1'b0, {W{1'b0}}};

    // Expected {load_rdy, expire_vld, busy, cnt} for the current cycle.
    function automatic logic [W+2:0] model_out();
        if (!m_active) return IDLE_OUT;
        if (m_cyc < m_deadline) return {1'b0, 1'b0, 1'b1, W'(m_deadline - m_cyc)};
        return {1'b0, 1'b1, 1'b1, {W{1'b0}}};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle at negedge.
    task automatic tick(input logic lv, input logic [W-1:0] lc, input logic ab,
                        input logic er, input logic rn);
        load_vld_i   = lv;
        load_cnt_i   = lc;
        abort_i      = ab;
        expire_rdy_i = er;
        rst_n        = rn;
        @(posedge clk);
        if (!rn) begin
            m_active = 1'b0;
            m_reload = '0;
        end else if (!m_active) begin
            if (lv) begin
                m_active   = 1'b1;
                m_deadline = m_cyc + longint'(lc) + 1;
                m_reload   = lc;
            end
        end else if (ab) begin
            m_active = 1'b0;
            m_reload = '0;
        end else if (m_cyc >= m_deadline && er) begin
`ifdef DEC_TIMER_AUTORELOAD_EN
            if (m_reload != '0) m_deadline = m_cyc + longint'(m_reload) + 1;
            else m_active = 1'b0;
`else
            m_active = 1'b0;
`endif
        end
        m_cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, W'(5), 1'b1, 1'b1, 1'b0);
        checks++;
        if (dut_out !== IDLE_OUT) begin
            errors++;
            $display("FAIL reset: got %h expected %h", dut_out, IDLE_OUT);
        end
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_load_n3();
        tick(1'b1, W'(3), 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (dut_out !== model_out()) begin
                errors++;
                $display("FAIL load_n3 k=%0d: got %h expected %h", k, dut_out, model_out());
            end
            if (k <= 3) begin
                checks++;
                if (cnt_o !== W'(4 - k)) begin
                    errors++;
                    $display("FAIL load_n3_cnt k=%0d: got %0d expected %0d", k, cnt_o, 4 - k);
                end
            end
            if (k == 4) begin
                checks++;
                if (expire_vld_o !== 1'b1) begin
                    errors++;
                    $display("FAIL load_n3_expire: got %b expected 1", expire_vld_o);
                end
            end
            tick(1'b0, W'($urandom), 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic test_zero();
        tick(1'b1, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({expire_vld_o, busy_o, cnt_o} !== {1'b1, 1'b1, {W{1'b0}}}) begin
            errors++;
            $display("FAIL zero_expire: got vld=%b busy=%b cnt=%0d expected 1 1 0",
                     expire_vld_o, busy_o, cnt_o);
        end
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (dut_out !== model_out()) begin
            errors++;
            $display("FAIL zero_idle: got %h expected %h", dut_out, model_out());
        end
    endtask

    task automatic test_backpressure();
        tick(1'b1, W'(2), 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (dut_out !== model_out()) begin
                errors++;
                $display("FAIL backpressure k=%0d: got %h expected %h", k, dut_out, model_out());
            end
            tick(1'b1, W'($urandom), 1'b0, 1'b0, 1'b1);
        end
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (dut_out !== IDLE_OUT) begin
            errors++;
            $display("FAIL backpressure_release: got %h expected %h", dut_out, IDLE_OUT);
        end
    endtask

    task automatic test_abort();
        tick(1'b1, W'(8), 1'b0, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (cnt_o !== W'(5)) begin
            errors++;
            $display("FAIL abort_precnt: got %0d expected 5", cnt_o);
        end
        tick(1'b0, '0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (dut_out !== IDLE_OUT) begin
                errors++;
                $display("FAIL abort_idle k=%0d: got %h expected %h", k, dut_out, IDLE_OUT);
            end
            tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic test_abort_races();
        // Abort with a same-cycle expiry handshake.
        tick(1'b1, W'(1), 1'b0, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (expire_vld_o !== 1'b1) begin
            errors++;
            $display("FAIL race_expire: got %b expected 1", expire_vld_o);
        end
        tick(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (dut_out !== IDLE_OUT) begin
            errors++;
            $display("FAIL race_abort_rdy: got %h expected %h", dut_out, IDLE_OUT);
        end
        // Abort in the cycle RUN would reach zero.
        tick(1'b1, W'(1), 1'b0, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (dut_out !== IDLE_OUT) begin
            errors++;
            $display("FAIL race_abort_zero: got %h expected %h", dut_out, IDLE_OUT);
        end
        // Abort in IDLE is ignored; the load still lands.
        tick(1'b1, '0, 1'b1, 1'b1, 1'b1);
        checks++;
        if ({expire_vld_o, busy_o} !== 2'b11) begin
            errors++;
            $display("FAIL idle_abort_load: got vld=%b busy=%b expected 1 1", expire_vld_o, busy_o);
        end
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_midrun();
        tick(1'b1, W'(6), 1'b0, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (cnt_o !== W'(4)) begin
            errors++;
            $display("FAIL midrun_cnt: got %0d expected 4", cnt_o);
        end
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut_out !== IDLE_OUT) begin
            errors++;
            $display("FAIL midrun_reset: got %h expected %h", dut_out, IDLE_OUT);
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
            checks++;
            if (expire_vld_o !== 1'b0) begin
                errors++;
                $display("FAIL midrun_noexpire k=%0d: got %b expected 0", k, expire_vld_o);
            end
        end
    endtask

    task automatic test_full_scale();
        int expire_at;
        expire_at = -1;
        tick(1'b1, {W{1'b1}}, 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= (1 << W) + 1; k++) begin
            checks++;
            if (dut_out !== model_out()) begin
                errors++;
                $display("FAIL full_scale k=%0d: got %h expected %h", k, dut_out, model_out());
            end
            if (expire_vld_o === 1'b1 && expire_at < 0) expire_at = k;
            tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
        end
        checks++;
        if (expire_at != (1 << W)) begin
            errors++;
            $display("FAIL full_scale_latency: got %0d expected %0d", expire_at, 1 << W);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        tick(1'b1, W'(2), 1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (dut_out !== model_out()) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got %h expected %h", k, dut_out, model_out());
            end
            if (expire_vld_o === 1'b1) pulses++;
            tick(1'b1, W'(2), 1'b0, 1'b1, 1'b1);
        end
        tick(1'b0, '0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
`ifdef DEC_TIMER_AUTORELOAD_EN
        // Periodic: expiries at cycles 3, 6, 9.
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL autoreload_pulses: got %0d expected 3", pulses);
        end
`else
        // Reloading through IDLE costs one extra cycle: expiries at cycles 3 and 7.
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL reload_pulses: got %0d expected 2", pulses);
        end
`endif
        checks++;
        if (dut_out !== IDLE_OUT) begin
            errors++;
            $display("FAIL back_to_back_abort: got %h expected %h", dut_out, IDLE_OUT);
        end
    endtask

    task automatic test_random();
        logic         lv, ab, er, rn;
        logic [W-1:0] lc;
        for (int k = 0; k < 3000; k++) begin
            lv = ($urandom_range(0, 99) < 30);
            lc = ($urandom_range(0, 19) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
            ab = ($urandom_range(0, 99) < 4);
            er = ($urandom_range(0, 99) < 50);
            rn = ($urandom_range(0, 199) != 0);
            tick(lv, lc, ab, er, rn);
            checks++;
            if (dut_out !== model_out()) begin
                errors++;
                $display("FAIL random k=%0d: got %h expected %h", k, dut_out, model_out());
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        load_vld_i   = 1'b0;
        load_cnt_i   = '0;
        abort_i      = 1'b0;
        expire_rdy_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_n3();
        test_zero();
        test_backpressure();
        test_abort();
        test_abort_races();
        test_reset_midrun();
        test_full_scale();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
